dram_port_arbiter: RTL

Round-robin arbiter that shares one single-port 32-bit data memory among the four processor cores. Each core issues a word request (read or write) with a req/ack handshake. The arbiter serialises these requests onto the memory port and returns read data per core. It also registers the four `End_core` flags into a global completion signal that the result-dump logic uses.

---
 rtl/dram_port_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin arbiter sharing one single-port data memory
// among four processor cores, plus the global completion flag.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_x/we_x/addr_x/dataIn_x per-core request (held until ack_x)
//   ack_x                      one-cycle completion pulse per core
//   dataOut_x                  per-core read-data register
//   mem_addr/mem_we/mem_dataIn memory port (write commits on clk edge)
//   mem_dataOut                combinational memory read data for mem_addr
//   End_core0..3               core-finished flags
//   all_done                   sticky registered AND of End_core flags
//   addr_err                   pulses with the ack of an out-of-range access
module dram_port_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MEM_DEPTH = 3075
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              req_3,
  input  logic              we_0,
  input  logic              we_1,
  input  logic              we_2,
  input  logic              we_3,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [ADDR_W-1:0] addr_3,
  input  logic [DATA_W-1:0] dataIn_0,
  input  logic [DATA_W-1:0] dataIn_1,
  input  logic [DATA_W-1:0] dataIn_2,
  input  logic [DATA_W-1:0] dataIn_3,
  output logic              ack_0,
  output logic              ack_1,
  output logic              ack_2,
  output logic              ack_3,
  output logic [DATA_W-1:0] dataOut_0,
  output logic [DATA_W-1:0] dataOut_1,
  output logic [DATA_W-1:0] dataOut_2,
  output logic [DATA_W-1:0] dataOut_3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  input  logic              End_core0,
  input  logic              End_core1,
  input  logic              End_core2,
  input  logic              End_core3,
  output logic              all_done,
  output logic              addr_err
);

  localparam int unsigned NCORE = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Per-core inputs gathered into indexable form
  logic [NCORE-1:0]  req_v;
  logic [NCORE-1:0]  we_v;
  logic [ADDR_W-1:0] addr_v [NCORE];
  logic [DATA_W-1:0] data_v [NCORE];

  assign req_v     = {req_3, req_2, req_1, req_0};
  assign we_v      = {we_3, we_2, we_1, we_0};
  assign addr_v[0] = addr_0;
  assign addr_v[1] = addr_1;
  assign addr_v[2] = addr_2;
  assign addr_v[3] = addr_3;
  assign data_v[0] = dataIn_0;
  assign data_v[1] = dataIn_1;
  assign data_v[2] = dataIn_2;
  assign data_v[3] = dataIn_3;

  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        win_q, win_d;
  logic              lat_we_q, lat_we_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dataIn_q, mem_dataIn_d;
  logic              mem_we_q, mem_we_d;
  logic [NCORE-1:0]  ack_q, ack_d;
  logic              addr_err_q, addr_err_d;
  logic              all_done_q, all_done_d;
  logic [DATA_W-1:0] dout_q [NCORE];
  logic [DATA_W-1:0] dout_d [NCORE];

  // Round-robin pick: priority last+1, last+2, last+3, last
  logic [NCORE-1:0] elig;
  logic [1:0]       cand;
  logic [1:0]       grant_idx;
  logic             grant_vld;

  always_comb begin
    elig      = req_v & {NCORE{~all_done_q}};
    cand      = last_q;
    grant_idx = last_q;
    grant_vld = 1'b0;
    // The core being acked this cycle must not be re-granted off its old req
    if (state_q == S_RESP) elig[win_q] = 1'b0;
    for (int i = 1; i <= int'(NCORE); i++) begin
      cand = last_q + 2'(i);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    lat_we_d     = lat_we_q;
    oor_d        = oor_q;
    mem_addr_d   = mem_addr_q;
    mem_dataIn_d = mem_dataIn_q;
    mem_we_d     = 1'b0;
    ack_d        = '0;
    addr_err_d   = 1'b0;
    all_done_d   = all_done_q | (End_core0 & End_core1 & End_core2 & End_core3);
    for (int i = 0; i < int'(NCORE); i++) dout_d[i] = dout_q[i];

    unique case (state_q)
      S_ACCESS: begin
        state_d      = S_RESP;
        ack_d[win_q] = 1'b1;
        addr_err_d   = oor_q;
        if (!lat_we_q) dout_d[win_q] = oor_q ? '0 : mem_dataOut;
      end
      default: begin
        // IDLE and RESP both arbitrate; memory port is latched on grant
        if (grant_vld) begin
          state_d      = S_ACCESS;
          win_d        = grant_idx;
          last_d       = grant_idx;
          lat_we_d     = we_v[grant_idx];
          mem_addr_d   = addr_v[grant_idx];
          mem_dataIn_d = data_v[grant_idx];
          oor_d        = 32'(addr_v[grant_idx]) >= MEM_DEPTH;
          mem_we_d     = we_v[grant_idx] && (32'(addr_v[grant_idx]) < MEM_DEPTH);
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= 2'd3;
      win_q        <= 2'd0;
      lat_we_q     <= 1'b0;
      oor_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_dataIn_q <= '0;
      mem_we_q     <= 1'b0;
      ack_q        <= '0;
      addr_err_q   <= 1'b0;
      all_done_q   <= 1'b0;
      for (int i = 0; i < int'(NCORE); i++) dout_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      lat_we_q     <= lat_we_d;
      oor_q        <= oor_d;
      mem_addr_q   <= mem_addr_d;
      mem_dataIn_q <= mem_dataIn_d;
      mem_we_q     <= mem_we_d;
      ack_q        <= ack_d;
      addr_err_q   <= addr_err_d;
      all_done_q   <= all_done_d;
      for (int i = 0; i < int'(NCORE); i++) dout_q[i] <= dout_d[i];
    end
  end

  assign ack_0      = ack_q[0];
  assign ack_1      = ack_q[1];
  assign ack_2      = ack_q[2];
  assign ack_3      = ack_q[3];
  assign dataOut_0  = dout_q[0];
  assign dataOut_1  = dout_q[1];
  assign dataOut_2  = dout_q[2];
  assign dataOut_3  = dout_q[3];
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_dataIn = mem_dataIn_q;
  assign all_done   = all_done_q;
  assign addr_err   = addr_err_q;

endmodule
